// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings and ramp direction.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF     = 2'b00;
    localparam mode_t MODE_BLINK   = 2'b01;
    localparam mode_t MODE_RUN     = 2'b10;
    localparam mode_t MODE_BREATHE = 2'b11;

    typedef enum logic {
        RAMP_UP   = 1'b0,
        RAMP_DOWN = 1'b1
    } ramp_t;

endpackage

// File: rtl/tick_gen.sv
// Parametrised divider: counts 0..DIV-1 while en=1 and flags the terminal-count cycle.
// Latency: tc is combinational from the count register (asserted during the TC cycle).
// Backpressure: en=0 holds the count; clr forces the count to 0 and wins over en.
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   en        advance the count this cycle
//   clr       synchronous clear of the count
//   tc        high while count==DIV-1 and en=1
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    // A divide-by-one still needs a one-bit register to keep the widths legal.
    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);
    assign tc      = en && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: off / blink / running light / PWM breathing.
// Latency: led and tick change on the edge closing a step TC cycle; a mode change shows on led one cycle later.
// Backpressure: none; en=0 freezes every counter and output (tick forced low), mode changes still re-init.
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   en        1 = run, 0 = freeze
//   mode      00 off, 01 blink, 10 run, 11 breathe
//   dir       running-light direction, 0 = toward MSB, 1 = toward LSB (sampled at step)
//   led       registered LED drive, 1 = lit
//   tick      registered one-cycle pulse per step
module led_pattern_gen #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int STEP_MS       = 1000,
    parameter int N_LED         = 4,
    parameter int PWM_W         = 8,
    parameter int DUTY_STEP_CYC = 100_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [N_LED-1:0] led,
    output logic             tick
);

    import led_pkg::*;

    localparam int                STEP_CYC = CLK_HZ / 1000 * STEP_MS;
    localparam logic [N_LED-1:0]  LED_LSB  = N_LED'(1);
    localparam logic [N_LED-1:0]  LED_MSB  = LED_LSB << (N_LED - 1);
    localparam logic [PWM_W-1:0]  DUTY_MAX = '1;
    localparam logic [PWM_W-1:0]  DUTY_MIN = '0;

    if (STEP_CYC < 2) begin : g_chk_step
        $error("led_pattern_gen: STEP_CYC must be at least 2");
    end
    if (N_LED < 1) begin : g_chk_nled
        $error("led_pattern_gen: N_LED must be at least 1");
    end
    if (DUTY_STEP_CYC < 1) begin : g_chk_duty
        $error("led_pattern_gen: DUTY_STEP_CYC must be at least 1");
    end
    if (PWM_W < 1) begin : g_chk_pwm
        $error("led_pattern_gen: PWM_W must be at least 1");
    end

    mode_t            mode_q,    mode_d;
    logic [N_LED-1:0] led_q,     led_d;
    logic             tick_q,    tick_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_W-1:0] duty_q,    duty_d;
    ramp_t            ramp_q,    ramp_d;

    logic re_init;
    logic step_tc;
    logic duty_tc;

    // Any change of the requested mode restarts the pattern from its initial value.
    assign re_init = (mode_t'(mode) != mode_q);

    tick_gen #(.DIV(STEP_CYC)) u_step_tick (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (re_init),
        .tc  (step_tc)
    );

    tick_gen #(.DIV(DUTY_STEP_CYC)) u_duty_tick (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (re_init),
        .tc  (duty_tc)
    );

    always_comb begin
        mode_d    = mode_t'(mode);
        led_d     = led_q;
        tick_d    = 1'b0;
        pwm_cnt_d = pwm_cnt_q;
        duty_d    = duty_q;
        ramp_d    = ramp_q;

        if (re_init) begin
            // Re-init beats a coincident step: no toggle, no tick.
            pwm_cnt_d = '0;
            duty_d    = '0;
            ramp_d    = RAMP_UP;
            led_d     = '0;
            if (mode_t'(mode) == MODE_RUN) begin
                led_d = dir ? LED_MSB : LED_LSB;
            end
        end else if (en) begin
            tick_d    = step_tc;
            pwm_cnt_d = pwm_cnt_q + 1'b1;
            case (mode_q)
                MODE_BLINK: begin
                    if (step_tc) led_d = ~led_q;
                end
                MODE_RUN: begin
                    // Shift-and-or rotate also degenerates correctly for a single channel.
                    if (step_tc) begin
                        led_d = dir ? ((led_q >> 1) | (led_q << (N_LED - 1)))
                                    : ((led_q << 1) | (led_q >> (N_LED - 1)));
                    end
                end
                MODE_BREATHE: begin
                    led_d = {N_LED{pwm_cnt_q < duty_q}};
                    if (duty_tc) begin
                        // The ramp turns on the same edge the duty hits an end stop.
                        if (ramp_q == RAMP_UP) begin
                            duty_d = duty_q + 1'b1;
                            if (duty_q + 1'b1 == DUTY_MAX) ramp_d = RAMP_DOWN;
                        end else begin
                            duty_d = duty_q - 1'b1;
                            if (duty_q - 1'b1 == DUTY_MIN) ramp_d = RAMP_UP;
                        end
                    end
                end
                default: begin
                    led_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_OFF;
            led_q     <= '0;
            tick_q    <= 1'b0;
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            ramp_q    <= RAMP_UP;
        end else begin
            mode_q    <= mode_d;
            led_q     <= led_d;
            tick_q    <= tick_d;
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            ramp_q    <= ramp_d;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with a 5-cycle step, 4 LEDs, 3-bit PWM, duty step every 2 cycles.
module tb_led_pattern_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       dir;
    logic [3:0] led;
    logic       tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    led_pattern_gen #(
        .CLK_HZ        (1000),
        .STEP_MS       (5),
        .N_LED         (4),
        .PWM_W         (3),
        .DUTY_STEP_CYC (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .dir  (dir),
        .led  (led),
        .tick (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       dir;
        int         n;
        logic [3:0] led;
        logic       tick;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic [1:0] m, input logic d, input int n,
                       input logic [3:0] l, input logic t);
        vec_t v;
        v.en = e; v.mode = m; v.dir = d; v.n = n; v.led = l; v.tick = t;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    logic [29:0] breathe_led;
    int          duty_exp [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        mode = 2'b00;
        dir  = 1'b0;
        // Bit i-1 is the expected LED level i cycles after breathe re-init.
        breathe_led = 30'b000011_00001111_01111111_00000000;

        #12;
        chk("reset_led",  32'(led),  32'h0);
        chk("reset_tick", 32'(tick), 32'h0);
        rst = 1'b0;

        // Blink from reset, freeze mid-step, collide a mode change with TC, run with dir flip.
        add(1, 2'b01, 0, 5, 4'b0000, 0);
        add(1, 2'b01, 0, 1, 4'b1111, 1);
        add(1, 2'b01, 0, 4, 4'b1111, 0);
        add(1, 2'b01, 0, 1, 4'b0000, 1);
        add(1, 2'b01, 0, 2, 4'b0000, 0);
        add(0, 2'b01, 0, 7, 4'b0000, 0);
        add(1, 2'b01, 0, 2, 4'b0000, 0);
        add(1, 2'b01, 0, 1, 4'b1111, 1);
        add(1, 2'b01, 0, 4, 4'b1111, 0);
        add(1, 2'b10, 0, 1, 4'b0001, 0);
        add(1, 2'b10, 0, 4, 4'b0001, 0);
        add(1, 2'b10, 0, 1, 4'b0010, 1);
        add(1, 2'b10, 0, 4, 4'b0010, 0);
        add(1, 2'b10, 0, 1, 4'b0100, 1);
        add(1, 2'b10, 0, 4, 4'b0100, 0);
        add(1, 2'b10, 0, 1, 4'b1000, 1);
        add(1, 2'b10, 0, 4, 4'b1000, 0);
        add(1, 2'b10, 0, 1, 4'b0001, 1);
        add(1, 2'b10, 0, 1, 4'b0001, 0);
        add(1, 2'b10, 1, 3, 4'b0001, 0);
        add(1, 2'b10, 1, 1, 4'b1000, 1);
        add(1, 2'b10, 1, 4, 4'b1000, 0);
        add(1, 2'b10, 1, 1, 4'b0100, 1);

        foreach (tbl[r]) begin
            en   = tbl[r].en;
            mode = tbl[r].mode;
            dir  = tbl[r].dir;
            for (int c = 0; c < tbl[r].n; c++) begin
                step();
                chk($sformatf("vec%0d_led", r),  32'(led),  32'(tbl[r].led));
                chk($sformatf("vec%0d_tick", r), 32'(tick), 32'(tbl[r].tick));
            end
        end

        // Breathe: duty ramps 0..7..0..1 one step per 2 cycles, led = pwm < duty.
        mode = 2'b11;
        dir  = 1'b0;
        step();
        chk("breathe_init_led",  32'(led),        32'h0);
        chk("breathe_init_tick", 32'(tick),       32'h0);
        chk("breathe_init_duty", 32'(dut.duty_q), 32'h0);
        for (int i = 1; i <= 30; i++) begin
            step();
            chk($sformatf("breathe%0d_led", i),  32'(led),  breathe_led[i-1] ? 32'hf : 32'h0);
            chk($sformatf("breathe%0d_tick", i), 32'(tick), (i % 5 == 0) ? 32'h1 : 32'h0);
            if (i % 2 == 0) begin
                chk($sformatf("breathe%0d_duty", i), 32'(dut.duty_q), 32'(duty_exp[i/2-1]));
            end
        end

        // Off: LEDs dark but the step tick keeps pulsing.
        mode = 2'b00;
        step();
        chk("off_init_led", 32'(led), 32'h0);
        chk("off_init_tick", 32'(tick), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("off%0d_led", i),  32'(led),  32'h0);
            chk($sformatf("off%0d_tick", i), 32'(tick), (i == 5) ? 32'h1 : 32'h0);
        end

        // Mode changes re-init even while frozen.
        en   = 1'b0;
        mode = 2'b01;
        step();
        chk("frozen_blink_led", 32'(led), 32'h0);
        mode = 2'b10;
        step();
        chk("frozen_run_led",  32'(led),  32'h1);
        chk("frozen_run_tick", 32'(tick), 32'h0);
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("resume%0d_led", i),  32'(led),  (i == 5) ? 32'h2 : 32'h1);
            chk($sformatf("resume%0d_tick", i), 32'(tick), (i == 5) ? 32'h1 : 32'h0);
        end

        // Asynchronous reset between edges, right after a step pulse.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_led",  32'(led),  32'h0);
        chk("async_rst_tick", 32'(tick), 32'h0);
        step();
        chk("held_rst_led", 32'(led), 32'h0);
        #2;
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk($sformatf("post_rst%0d_led", i),  32'(led),  (i == 6) ? 32'h2 : 32'h1);
            chk($sformatf("post_rst%0d_tick", i), 32'(tick), (i == 6) ? 32'h1 : 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
